// File: rtl/bcd_seq_converter.sv
// Sequential 16-bit binary to 5-digit BCD converter (double-dabble, one step per clock).
// Define SIGNED_MODE_EN to treat Value as two's complement and drive Negative.
module bcd_seq_converter (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] Value,
  output logic        Busy,
  output logic        Done,
  output logic [3:0]  Ten_thousand,
  output logic [3:0]  Thousand,
  output logic [3:0]  Hundred,
  output logic [3:0]  Ten,
  output logic [3:0]  One,
  output logic        Negative
);

  localparam int DATA_W = 16;
  localparam int BCD_W  = 20;
  localparam int STAGES = 16;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  op_q, op_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic               done_q, done_d;

  logic [DATA_W-1:0]        mag;
  logic [BCD_W-1:0]         bcd_adj;
  logic [BCD_W+DATA_W-1:0]  shifted;
  logic                     last_step;

  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int n = 0; n < BCD_W / 4; n++) begin
      if (b[n*4 +: 4] >= 4'd5)
        r[n*4 +: 4] = b[n*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef SIGNED_MODE_EN
  logic sign_q, sign_d, neg_q, neg_d;
  // Negating 0x8000 wraps to 0x8000, which is exactly the 32768 magnitude.
  assign mag = Value[15] ? (~Value + 16'd1) : Value;
`else
  assign mag = Value;
`endif

  assign bcd_adj   = bcd_adjust(bcd_q);
  assign shifted   = {bcd_adj, op_q} << 1;
  assign last_step = (cnt_q == 5'(STAGES - 1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = SHIFT;
      SHIFT:   if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_q != IDLE);
  end

  always_comb begin
    op_d     = op_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    done_d   = 1'b0;
`ifdef SIGNED_MODE_EN
    sign_d   = sign_q;
    neg_d    = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          op_d  = mag;
          bcd_d = '0;
          cnt_d = '0;
`ifdef SIGNED_MODE_EN
          sign_d = Value[15];
`endif
        end
      end
      SHIFT: begin
        op_d  = shifted[DATA_W-1:0];
        bcd_d = shifted[BCD_W+DATA_W-1:DATA_W];
        cnt_d = cnt_q + 5'd1;
        // The final step publishes its own result directly, so outputs land on the DONE edge.
        if (last_step) begin
          digits_d = shifted[BCD_W+DATA_W-1:DATA_W];
          done_d   = 1'b1;
`ifdef SIGNED_MODE_EN
          neg_d    = sign_q;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_q     <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      done_q   <= 1'b0;
`ifdef SIGNED_MODE_EN
      sign_q   <= 1'b0;
      neg_q    <= 1'b0;
`endif
    end else begin
      op_q     <= op_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      done_q   <= done_d;
`ifdef SIGNED_MODE_EN
      sign_q   <= sign_d;
      neg_q    <= neg_d;
`endif
    end
  end

  assign Done         = done_q;
  assign Ten_thousand = digits_q[19:16];
  assign Thousand     = digits_q[15:12];
  assign Hundred      = digits_q[11:8];
  assign Ten          = digits_q[7:4];
  assign One          = digits_q[3:0];
`ifdef SIGNED_MODE_EN
  assign Negative     = neg_q;
`else
  assign Negative     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed bench for bcd_seq_converter; expected digits written as packed BCD hex.
module tb_bcd_seq_converter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] Value = 16'h0;
  logic        Busy, Done, Negative;
  logic [3:0]  Ten_thousand, Thousand, Hundred, Ten, One;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  bcd_seq_converter dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Value(Value),
    .Busy(Busy), .Done(Done),
    .Ten_thousand(Ten_thousand), .Thousand(Thousand), .Hundred(Hundred),
    .Ten(Ten), .One(One), .Negative(Negative)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) if (Done) done_cnt++;

  function automatic logic [19:0] digits();
    return {Ten_thousand, Thousand, Hundred, Ten, One};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic run_conv(input string tag, input logic [15:0] v,
                          input logic [19:0] exp, input logic exp_neg);
    logic [19:0] prev;
    int n;
    prev = digits();
    done_cnt = 0;
    Value = v;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Value = ~v;
    chk({tag, "_busy"}, 32'(Busy), 32'd1);
    n = 0;
    while (!Done && n < 40) begin
      if (n == 8) chk({tag, "_hold"}, 32'(digits()), 32'(prev));
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 16);
    chk({tag, "_dig"}, 32'(digits()), 32'(exp));
    chk({tag, "_neg"}, 32'(Negative), 32'(exp_neg));
    tick();
    chk({tag, "_done_lo"}, 32'(Done), 32'd0);
    chk({tag, "_idle"}, 32'(Busy), 32'd0);
    chk({tag, "_pulses"}, done_cnt, 1);
  endtask

  initial begin
    int first, second, pulses;
    repeat (3) tick();
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_dig", 32'(digits()), 32'd0);
    chk("rst_neg", 32'(Negative), 32'd0);
    Start = 1'b1;
    tick();
    chk("rst_start_ignored", 32'(Busy), 32'd0);
    Start = 1'b0;
    Reset = 1'b0;
    tick();

    run_conv("v12345", 16'd12345, 20'h12345, 1'b0);
    run_conv("v9999", 16'd9999, 20'h09999, 1'b0);
    run_conv("v1000", 16'd1000, 20'h01000, 1'b0);
`ifdef SIGNED_MODE_EN
    run_conv("sFFFF", 16'hFFFF, 20'h00001, 1'b1);
    run_conv("s8000", 16'h8000, 20'h32768, 1'b1);
    run_conv("s7FFF", 16'h7FFF, 20'h32767, 1'b0);
`else
    run_conv("vFFFF", 16'hFFFF, 20'h65535, 1'b0);
`endif
    run_conv("v0", 16'd0, 20'h00000, 1'b0);

    // Ignored second Start and late Value change.
    done_cnt = 0;
    Value = 16'd100; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    Value = 16'd7;
    repeat (2) tick();
    Value = 16'd999; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (20) tick();
    chk("ign_pulses", done_cnt, 1);
    chk("ign_dig", 32'(digits()), 32'h00100);

    // Reset mid-conversion.
    done_cnt = 0;
    Value = 16'd4321; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (8) tick();
    Reset = 1'b1;
    #1;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_dig", 32'(digits()), 32'd0);
    tick();
    Reset = 1'b0;
    repeat (20) tick();
    chk("abort_pulses", done_cnt, 0);
    chk("abort_idle", 32'(Busy), 32'd0);
    run_conv("v4321", 16'd4321, 20'h04321, 1'b0);

    // Start held continuously.
    first = -1; second = -1; pulses = 0;
    Value = 16'd9; Start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Done) begin
        pulses++;
        if (first < 0) first = i; else if (second < 0) second = i;
        chk("hold_dig", 32'(digits()), 32'h00009);
      end
    end
    Start = 1'b0;
    chk("hold_pulses", pulses, 2);
    chk("hold_first", first, 16);
    chk("hold_spacing", second - first, 18);
    repeat (25) tick();
    chk("hold_drain", 32'(Busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
